apple_field_writer: RTL and testbench
=====================================

Name: apple_field_writer

Overview:
- Owns the packed snake game field register (3 bits per cell) and is the writer side of the free-cell search.
- Drives the field and a seed to the combinational free-cell finder, which returns a candidate apple bit offset.
- On a spawn request, writes the apple code into the returned cell after an occupancy check.
- Also gives the snake logic a single-cell write port.

Parameters:
SIZE_X, 8'd10, field width in cells
SIZE_Y, 8'd10, field height in cells
FIELD_SIZE, (SIZE_X*SIZE_Y)*3, packed field width in bits
SBITS, $clog2(SIZE_X*SIZE_Y), cell index / seed width
POSBITS, $clog2(FIELD_SIZE), bit-offset width
APPLE_CODE, 3'd4, cell code written for an apple (must be nonzero)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
spawn_req  input  1  request to place one apple; sampled only in IDLE
apple_pos  input  POSBITS  candidate bit offset from the finder (cell index * 3)
cell_we  input  1  snake-side cell write enable
cell_idx  input  SBITS  snake-side cell index
cell_val  input  3  snake-side cell code (0 = empty)
field  output  FIELD_SIZE  registered packed field, cell i at bits [3i+2:3i]
seed  output  SBITS  registered seed to the finder
busy  output  1  spawn in progress
spawn_done  output  1  one-cycle pulse: spawn finished
spawn_fail  output  1  valid with spawn_done: no apple written

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - field: all zeros (all cells empty).
  - seed, busy, spawn_done, spawn_fail: 0.
  - free-running counter cnt: 0.
  - state: IDLE.
- cnt:
  - Increments every cycle, modulo SIZE_X*SIZE_Y (SIZE_X*SIZE_Y-1 wraps to 0).
  - Independent of state.
- FSM states IDLE, SETTLE, WRITE:
  - IDLE: on an edge with spawn_req=1, load seed <= cnt, set busy <= 1, go to SETTLE. spawn_req=0 stays in IDLE.
  - SETTLE: one cycle. seed holds steady so the finder output can settle. Go to WRITE.
  - WRITE: at the edge, evaluate apple_pos against the current field value.
    - Success requires all of: apple_pos < FIELD_SIZE, apple_pos divisible by 3, and the cell at apple_pos/3 equal to 0.
    - On success, write APPLE_CODE to that cell.
    - Either way, at the same edge: spawn_done <= 1, spawn_fail <= !success, busy <= 0, go to IDLE.
- Pulse timing:
  - spawn_done is high for exactly the one cycle after the WRITE edge; spawn_fail is 0 whenever spawn_done is 0.
  - Request-to-done latency: 3 edges (IDLE sample, SETTLE, WRITE); the field update is visible together with spawn_done.
- Request handling:
  - spawn_req while busy is ignored, not queued.
  - spawn_req held high continuously starts a new spawn in the IDLE cycle that follows spawn_done.
- seed changes only on an IDLE-accepted request and otherwise holds its value.
- cell_we:
  - Writes cell_val to cell cell_idx at the edge, in any state.
  - Ignored when cell_idx >= SIZE_X*SIZE_Y.
- Simultaneous writes at the WRITE edge:
  - cell_we to the same cell as the apple: cell_we wins, and the spawn still reports success per the check done on the pre-edge field.
  - cell_we to a different cell: both writes take effect.
- A cell_we that fills the candidate cell during SETTLE makes the WRITE check fail (spawn_fail=1).
- Reset asserted mid-spawn: immediate return to reset values, including field cleared. No spawn_done is emitted.
- Width rules:
  - The cell index is computed as apple_pos/3 in POSBITS width, then truncated to SBITS only after the range check.
  - No other arithmetic overflow is permitted.

Test Plan:
(bench uses SIZE_X=4, SIZE_Y=4: FIELD_SIZE=48, SBITS=4, POSBITS=6)
- Reset: rst pulse mid-cycle -> field=0, seed=0, busy=0, spawn_done=0 asynchronously. cnt reads 5 after 5 edges and wraps 15->0.
- Basic spawn: empty field, spawn_req at cnt=7, finder model returns apple_pos=21. Required response:
  - seed=7 from the next edge.
  - spawn_done=1, spawn_fail=0 three edges after request.
  - field[23:21]=3'd4 from the same cycle; all other bits 0.
- Occupied cell: cell 7 preset to 3'd1 via cell_we, then spawn with apple_pos=21 -> spawn_fail=1 with spawn_done; field unchanged.
- Bad position: apple_pos=48 (out of range), then apple_pos=22 (unaligned) -> each yields spawn_fail=1; no field change.
- Collision at WRITE edge: cell_we idx=7 val=3'd2 on the WRITE edge with apple_pos=21 -> field[23:21]=3'd2, spawn_fail=0. Repeat with idx=3 -> both cell 3=3'd2 and cell 7=3'd4.
- Busy/reset: spawn_req pulsed in SETTLE -> ignored, exactly one spawn_done. Then rst asserted in WRITE -> no spawn_done pulse, field cleared, state IDLE.

Source files
------------

// File: rtl/apple_field_writer.sv
// apple_field_writer: owns the packed snake field and places apples at finder-supplied offsets.
module apple_field_writer #(
  parameter int SIZE_X = 10,
  parameter int SIZE_Y = 10,
  parameter int FIELD_SIZE = (SIZE_X * SIZE_Y) * 3,
  parameter int SBITS = $clog2(SIZE_X * SIZE_Y),
  parameter int POSBITS = $clog2(FIELD_SIZE),
  parameter logic [2:0] APPLE_CODE = 3'd4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spawn_req,
  input  logic [POSBITS-1:0]    apple_pos,
  input  logic                  cell_we,
  input  logic [SBITS-1:0]      cell_idx,
  input  logic [2:0]            cell_val,
  output logic [FIELD_SIZE-1:0] field,
  output logic [SBITS-1:0]      seed,
  output logic                  busy,
  output logic                  spawn_done,
  output logic                  spawn_fail
);
  localparam int CELLS = SIZE_X * SIZE_Y;
  typedef enum logic [1:0] {IDLE, SETTLE, WRITE} state_t;
  state_t r_state, w_state_nxt;
  logic [FIELD_SIZE-1:0] r_field;
  logic [SBITS-1:0] r_seed, r_cnt;
  logic r_busy, r_done, r_fail;
  logic [POSBITS-1:0] w_div;
  logic [SBITS-1:0] w_idx;
  logic w_ok, w_we_ok;
  // divide at full offset width; truncation is harmless once the range check has passed
  assign w_div = apple_pos / POSBITS'(3);
  assign w_idx = SBITS'(w_div);
  assign w_ok = (32'(apple_pos) < FIELD_SIZE) && (apple_pos % POSBITS'(3) == '0) &&
                (r_field[32'(w_idx) * 3 +: 3] == 3'd0);
  assign w_we_ok = cell_we && (32'(cell_idx) < CELLS);
  always_comb begin
    w_state_nxt = (r_state == IDLE) ? (spawn_req ? SETTLE : IDLE) :
                  (r_state == SETTLE) ? WRITE : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_field <= '0;
      r_seed  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_cnt == SBITS'(CELLS - 1)) ? '0 : r_cnt + 1'b1;
      r_done  <= r_state == WRITE;
      r_fail  <= (r_state == WRITE) && !w_ok;
      if (r_state == IDLE && spawn_req) begin
        r_seed <= r_cnt;
        r_busy <= 1'b1;
      end
      if (r_state == WRITE) r_busy <= 1'b0;
      if (r_state == WRITE && w_ok) r_field[32'(w_idx) * 3 +: 3] <= APPLE_CODE;
      // snake write comes last so it overrides an apple landing on the same cell
      if (w_we_ok) r_field[32'(cell_idx) * 3 +: 3] <= cell_val;
    end
  end
  assign field      = r_field;
  assign seed       = r_seed;
  assign busy       = r_busy;
  assign spawn_done = r_done;
  assign spawn_fail = r_fail;
endmodule

// File: tb/tb_apple_field_writer.sv
// tb_apple_field_writer: directed checks of apple placement on a 4x4 field.
module tb_apple_field_writer;
  logic clk = 1'b0, rst = 1'b1, spawn_req = 1'b0, cell_we = 1'b0;
  logic [5:0] apple_pos = '0;
  logic [3:0] cell_idx = '0;
  logic [2:0] cell_val = '0;
  logic [47:0] field;
  logic [3:0] seed;
  logic busy, spawn_done, spawn_fail;
  int n_chk = 0, n_fail = 0, m_cnt = 0;
  apple_field_writer #(.SIZE_X(4), .SIZE_Y(4)) dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req), .apple_pos(apple_pos),
    .cell_we(cell_we), .cell_idx(cell_idx), .cell_val(cell_val),
    .field(field), .seed(seed), .busy(busy),
    .spawn_done(spawn_done), .spawn_fail(spawn_fail)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    m_cnt = rst ? 0 : (m_cnt + 1) % 16;
  endtask
  task automatic wait_cnt(input int v);
    while (m_cnt != v) tick;
  endtask
  task automatic poke(input logic [3:0] idx, input logic [2:0] val);
    cell_we = 1'b1; cell_idx = idx; cell_val = val;
    tick;
    cell_we = 1'b0;
  endtask
  // we_at: 0 none, 1 snake write on the SETTLE edge, 2 on the WRITE edge
  task automatic spawn(input string tag, input logic [5:0] pos, input int we_at,
                       input logic [3:0] idx, input logic [2:0] val,
                       input logic exp_fail, input logic [47:0] exp_field);
    int s;
    s = m_cnt;
    spawn_req = 1'b1; apple_pos = pos;
    tick;
    spawn_req = 1'b0;
    chk({tag, "_seed"}, seed, s);
    chk({tag, "_busy1"}, busy, 1);
    chk({tag, "_nodone1"}, spawn_done, 0);
    cell_we = (we_at == 1); cell_idx = idx; cell_val = val;
    tick;
    chk({tag, "_nodone2"}, spawn_done, 0);
    cell_we = (we_at == 2);
    tick;
    cell_we = 1'b0;
    chk({tag, "_done"}, spawn_done, 1);
    chk({tag, "_fail"}, spawn_fail, exp_fail);
    chk({tag, "_busy0"}, busy, 0);
    chk({tag, "_field"}, field, exp_field);
    tick;
    chk({tag, "_pulse_end"}, {spawn_done, spawn_fail}, 0);
  endtask
  initial begin
    tick; tick;
    rst = 1'b0;
    chk("rst_field", field, 0);
    chk("rst_seed", seed, 0);
    chk("rst_flags", {busy, spawn_done, spawn_fail}, 0);
    wait_cnt(5);
    spawn("cnt5_oob", 6'd48, 0, 4'd0, 3'd0, 1'b1, 48'h0);
    chk("seed_is5", seed, 5);
    wait_cnt(0);
    spawn("wrap_unaligned", 6'd22, 0, 4'd0, 3'd0, 1'b1, 48'h0);
    chk("seed_wrap0", seed, 0);
    wait_cnt(7);
    spawn("basic", 6'd21, 0, 4'd0, 3'd0, 1'b0, 48'h800000);
    chk("seed_is7", seed, 7);
    poke(4'd7, 3'd1);
    chk("preset7", field, 48'h200000);
    spawn("occupied", 6'd21, 0, 4'd0, 3'd0, 1'b1, 48'h200000);
    poke(4'd7, 3'd0);
    spawn("coll_same", 6'd21, 2, 4'd7, 3'd2, 1'b0, 48'h400000);
    poke(4'd7, 3'd0);
    spawn("coll_other", 6'd21, 2, 4'd3, 3'd2, 1'b0, 48'h800400);
    poke(4'd7, 3'd0);
    poke(4'd3, 3'd0);
    spawn("settle_fill", 6'd21, 1, 4'd7, 3'd1, 1'b1, 48'h200000);
    poke(4'd7, 3'd0);
    chk("cleared", field, 0);
    begin
      int s;
      s = m_cnt;
      spawn_req = 1'b1; apple_pos = 6'd0;
      tick;
      spawn_req = 1'b1;
      tick;
      spawn_req = 1'b0;
      chk("busy_nodone", spawn_done, 0);
      tick;
      chk("busy_done", spawn_done, 1);
      chk("busy_field", field, 48'h4);
      chk("busy_seed", seed, s);
      for (int i = 0; i < 4; i++) begin
        tick;
        chk("busy_single", {spawn_done, busy}, 0);
      end
    end
    spawn_req = 1'b1; apple_pos = 6'd3;
    tick;
    spawn_req = 1'b0;
    tick;
    #4 rst = 1'b1;
    #1;
    chk("async_field", field, 0);
    chk("async_seed", seed, 0);
    chk("async_flags", {busy, spawn_done, spawn_fail}, 0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_nodone", spawn_done, 0);
    end
    spawn("after_rst", 6'd3, 0, 4'd0, 3'd0, 1'b0, 48'h20);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
